// File: rtl/ysyx_lsu_l1d_pkg.sv
// Shared LSU definitions: FSM states, op codes, cacheable regions, size masks.
package ysyx_lsu_l1d_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [3:0] ysyx_ALU_OP_LB  = 4'd0;
  localparam logic [3:0] ysyx_ALU_OP_LBU = 4'd1;
  localparam logic [3:0] ysyx_ALU_OP_LH  = 4'd2;
  localparam logic [3:0] ysyx_ALU_OP_LHU = 4'd3;
  localparam logic [3:0] ysyx_ALU_OP_LW  = 4'd4;
  localparam logic [3:0] ysyx_ALU_OP_SB  = 4'd5;
  localparam logic [3:0] ysyx_ALU_OP_SH  = 4'd6;
  localparam logic [3:0] ysyx_ALU_OP_SW  = 4'd7;

  // Cacheable windows, [lo, hi)
  localparam logic [31:0] REGION0_LO = 32'h3000_0000;
  localparam logic [31:0] REGION0_HI = 32'h4000_0000;
  localparam logic [31:0] REGION1_LO = 32'h8000_0000;
  localparam logic [31:0] REGION1_HI = 32'h8040_0000;
  localparam logic [31:0] REGION2_LO = 32'ha000_0000;
  localparam logic [31:0] REGION2_HI = 32'hc000_0000;

  localparam logic [3:0] SIZE_B = 4'h1;
  localparam logic [3:0] SIZE_H = 4'h3;
  localparam logic [3:0] SIZE_W = 4'hf;

  function automatic logic [3:0] size_mask(input logic [3:0] op);
    case (op)
      ysyx_ALU_OP_LB, ysyx_ALU_OP_LBU, ysyx_ALU_OP_SB: return SIZE_B;
      ysyx_ALU_OP_LH, ysyx_ALU_OP_LHU, ysyx_ALU_OP_SH: return SIZE_H;
      default:                                          return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (size_mask(op))
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_cacheable(input logic [31:0] a);
    return (a >= REGION0_LO && a < REGION0_HI) ||
           (a >= REGION1_LO && a < REGION1_HI) ||
           (a >= REGION2_LO && a < REGION2_HI);
  endfunction

  // Align the addressed bytes down to bit 0, then extend per load op
  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (op)
      ysyx_ALU_OP_LB:  return {{24{sh[7]}}, sh[7:0]};
      ysyx_ALU_OP_LBU: return {24'h0, sh[7:0]};
      ysyx_ALU_OP_LH:  return {{16{sh[15]}}, sh[15:0]};
      ysyx_ALU_OP_LHU: return {16'h0, sh[15:0]};
      default:         return sh;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_l1d_array.sv
// Direct-mapped line storage: valid/tag/data, one comb read, one byte-enabled write.
module ysyx_lsu_l1d_array #(
  parameter int SETS  = 4,
  parameter int IDX_W = 2,
  parameter int TAG_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             inv_all
);

  logic [SETS-1:0]            valid_q;
  logic [SETS-1:0][TAG_W-1:0] tag_q;
  logic [SETS-1:0][31:0]      data_q;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Valid bits: invalidate-all beats a concurrent write so a flushed fill never lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       valid_q <= '0;
    else if (inv_all) valid_q <= '0;
    else if (wr_en)   valid_q[wr_idx] <= 1'b1;
  end

  // Tag and data need no reset; they are only trusted behind a valid bit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/ysyx_lsu_l1d.sv
// Load/store unit with a write-through, no-write-allocate direct-mapped L1D.
module ysyx_lsu_l1d
  import ysyx_lsu_l1d_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SETS     = 4,
  parameter int CACHE_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              flush,
  output logic [ADDR_W-1:0] lsu_araddr_o,
  output logic              lsu_arvalid_o,
  output logic [7:0]        lsu_rstrb_o,
  input  logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rvalid,
  output logic [ADDR_W-1:0] lsu_awaddr_o,
  output logic              lsu_awvalid_o,
  output logic [DATA_W-1:0] lsu_wdata_o,
  output logic [7:0]        lsu_wstrb_o,
  output logic              lsu_wvalid_o,
  input  logic              lsu_wready,
  output logic [31:0]       perf_hit_o,
  output logic [31:0]       perf_miss_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  lsu_state_e state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        strb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // In IDLE the lookup uses the incoming request; afterwards the latched one
  logic [ADDR_W-1:0] look_addr;
  logic [IDX_W-1:0]  look_idx;
  logic [TAG_W-1:0]  look_tag;
  logic              look_cacheable, look_hit;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              accept, req_mis;

  assign look_addr      = (state == LSU_IDLE) ? req_addr : addr_q;
  assign look_idx       = look_addr[IDX_W+1:2];
  assign look_tag       = look_addr[ADDR_W-1:IDX_W+2];
  assign look_cacheable = (CACHE_EN != 0) && is_cacheable(look_addr);
  assign look_hit       = rd_valid && (rd_tag == look_tag) && look_cacheable;
  assign accept         = req_valid && req_ready;
  assign req_mis        = is_misaligned(req_op, req_addr[1:0]);

  ysyx_lsu_l1d_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (look_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (look_idx),
    .wr_tag   (look_tag),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .inv_all  (flush)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake/bus valids, and array write control
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    lsu_arvalid_o = 1'b0;
    lsu_awvalid_o = 1'b0;
    lsu_wvalid_o  = 1'b0;
    wr_en         = 1'b0;
    wr_be         = 4'h0;
    wr_data       = 32'h0;
    case (state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_mis)       state_nxt = LSU_RESP;
          else if (req_wen)  state_nxt = LSU_STORE;
          else if (look_hit) state_nxt = LSU_RESP;
          else               state_nxt = LSU_LOAD;
        end
      end
      LSU_LOAD: begin
        lsu_arvalid_o = 1'b1;
        if (lsu_rvalid) begin
          state_nxt = LSU_RESP;
          wr_en     = look_cacheable;
          wr_be     = 4'hf;
          wr_data   = lsu_rdata;
        end
      end
      LSU_STORE: begin
        lsu_awvalid_o = 1'b1;
        lsu_wvalid_o  = 1'b1;
        if (lsu_wready) begin
          state_nxt = LSU_RESP;
          // Write-through: merge into a resident line, never allocate on miss
          wr_en     = look_hit;
          wr_be     = 4'(strb_q << addr_q[1:0]);
          wr_data   = wdata_q << {addr_q[1:0], 3'b000};
        end
      end
      default: begin
        resp_valid = 1'b1;
        state_nxt  = LSU_IDLE;
      end
    endcase
  end

  // Request latch and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      op_q    <= req_op;
      wdata_q <= req_wdata;
      strb_q  <= size_mask(req_op);
      err_q   <= req_mis;
      rdata_q <= (!req_mis && !req_wen && look_hit) ?
                 load_extend(req_op, rd_data, req_addr[1:0]) : '0;
    end else if (state == LSU_LOAD && lsu_rvalid) begin
      rdata_q <= load_extend(op_q, lsu_rdata, addr_q[1:0]);
    end
  end

  // Hit/miss counters for loads only; a flushed fill still counts as a miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
    end else begin
      if (accept && !req_mis && !req_wen && look_hit) perf_hit_o <= perf_hit_o + 32'd1;
      if (state == LSU_LOAD && lsu_rvalid && look_cacheable) perf_miss_o <= perf_miss_o + 32'd1;
    end
  end

  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign lsu_araddr_o = addr_q;
  assign lsu_awaddr_o = addr_q;
  assign lsu_wdata_o  = wdata_q;
  assign lsu_rstrb_o  = {4'h0, strb_q};
  assign lsu_wstrb_o  = {4'h0, strb_q};

endmodule

// File: doc/ysyx_lsu_l1d.md
Name: ysyx_lsu_l1d

Overview:
Parametrised load/store unit with a direct-mapped, write-through, no-write-allocate L1 data cache of SETS one-word lines. It sits between EXU and the load/store bus ports, with one request outstanding at a time. Compared with the single-entry predecessor it adds:
- configurable depth
- a registered request/response handshake
- store-hit byte merging instead of line invalidation
- misalignment detection, flush, and hit/miss counters

Parameters:
ADDR_W, 32, address width (only 32 supported)
DATA_W, 32, data width (only 32 supported)
SETS, 4, number of cache lines; power of two, at least 2
CACHE_EN, 1, 0 forces every access to the bus (no fills, no hits)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request (high only in IDLE)
req_addr  in  32  byte address
req_wen  in  1  1=store, 0=load
req_op  in  4  ysyx_ALU_OP_{LB,LBU,LH,LHU,LW,SB,SH,SW}
req_wdata  in  32  store data (low-aligned)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  aligned, extended load result; 0 for stores and errors
resp_err  out  1  misaligned access, valid with resp_valid
flush  in  1  invalidate all lines
lsu_araddr_o  out  32  load address
lsu_arvalid_o  out  1  load request
lsu_rstrb_o  out  8  load size mask (1/3/f, unshifted)
lsu_rdata  in  32  bus word
lsu_rvalid  in  1  load data valid
lsu_awaddr_o  out  32  store address
lsu_awvalid_o  out  1  store address valid
lsu_wdata_o  out  32  store data (low-aligned)
lsu_wstrb_o  out  8  store size mask (1/3/f, unshifted)
lsu_wvalid_o  out  1  store data valid
lsu_wready  in  1  store accepted
perf_hit_o  out  32  load hit counter, wraps
perf_miss_o  out  32  cacheable load miss counter, wraps

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE; all valid bits cleared.
  - req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
  - All bus valids=0, bus addresses/data/strobes=0; perf counters=0.
- Accept: a request is taken when req_valid & req_ready. addr, op, wen and wdata are latched; all bus outputs drive from the latched copies.
- Index/tag: idx=addr[log2(SETS)+1:2], tag=addr[31:log2(SETS)+2].
- Cacheable iff CACHE_EN and addr is in [0x30000000,0x40000000), [0x80000000,0x80400000) or [0xa0000000,0xc0000000).
- Misaligned access (half at addr[0]=1, word at addr[1:0]!=0):
  - no bus traffic, no cache change;
  - resp_valid=1, resp_err=1 in the cycle after accept.
- States: IDLE, LOAD, STORE, RESP.
  - IDLE, load hit (valid & tag match & cacheable) -> RESP. Result registered; resp_valid in the cycle after accept (latency 1); perf_hit increments.
  - IDLE, load miss -> LOAD. arvalid held high until lsu_rvalid.
    - On rvalid: if cacheable, fill line (data, tag, valid) and increment perf_miss.
    - Then -> RESP; resp_valid one cycle after rvalid.
  - IDLE, store -> STORE. awvalid and wvalid held together until lsu_wready.
    - On wready: if the line hits, merge bytes into the line at byte offset addr[1:0]; valid stays set. A miss does not allocate.
    - Then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- Load result: shift the word right by 8*addr[1:0], then per op:
  - LB/LH sign-extend;
  - LBU/LHU zero-extend;
  - LW passes through.
- Flush:
  - Clears all valid bits at the clock edge, in any state.
  - A fill coinciding with flush is suppressed (flush wins); the response still returns bus data.
  - A flush coinciding with an IDLE-state hit lookup does not change that response (lookup uses pre-edge state).
- resp_valid is never asserted in the same cycle as req_ready.

Decomposition:
- Shared header (ysyx_macro.v): LSU state encodings, the three cacheable region bounds, size-mask constants 8'h1/8'h3/8'hf.
- Sub-module ysyx_lsu_l1d_array holds valid/tag/data storage, with:
  - one combinational read port;
  - one write port carrying a 4-bit byte enable;
  - a synchronous invalidate-all input;
  - async active-low reset of the valid bits only.

Test Plan:
- LW 0x80000010 miss; bus returns 0xdeadbeef after 3 cycles -> arvalid held 3 cycles, resp_rdata=0xdeadbeef, perf_miss=1. Repeat the LW -> no arvalid, resp 1 cycle after accept, perf_hit=1.
- LB 0x80000013 after the fill above -> 0xffffffde. LHU 0x80000012 -> 0x0000dead.
- SB 0x80000011 wdata 0x55 (hit), wready after 2 cycles -> wstrb=0x1, wdata=0x55. A following LW 0x80000010 hits and returns 0xdead55ef.
- LW 0x10000000 (uncacheable) twice -> bus read both times, perf counters unchanged. LW 0x80000014 with SETS=4 evicts nothing at idx 1 but replaces an old tag at idx 1 when addr 0x80000024 is loaded.
- SH 0x80000003 -> resp_err=1, no awvalid. flush asserted in the same cycle as rvalid of a cacheable miss -> data returned, and the next identical load misses.
- Reset asserted while in LOAD with arvalid=1 -> arvalid drops immediately, req_ready=1, all lines invalid.
